spi_accel_responder: RTL and testbench

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

---
 rtl/spi_accel_responder_pkg.sv | 26 ++
 rtl/spi_pin_sync.sv | 55 +++++
 rtl/spi_accel_responder.sv | 199 +++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_responder_pkg.sv
// Shared constants, register map and FSM/mode enums for the SPI accelerometer responder.
package spi_accel_responder_pkg;

   localparam logic [7:0] CMD_WRITE     = 8'h0A;
   localparam logic [7:0] CMD_READ      = 8'h0B;

   localparam logic [7:0] ADDR_DEVID    = 8'h00;
   localparam logic [7:0] ADDR_REVID    = 8'h01;
   localparam logic [7:0] ADDR_X        = 8'h08;
   localparam logic [7:0] ADDR_Y        = 8'h09;
   localparam logic [7:0] ADDR_Z        = 8'h0A;
   localparam logic [7:0] ADDR_LIMIT    = 8'h40;

   localparam logic [7:0] DEVID_DEFAULT = 8'hAD;
   localparam logic [7:0] REVID_VAL     = 8'h1D;
   localparam int         REG_DEPTH     = 64;

   typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} spi_state_e;
   typedef enum logic [1:0] {MODE_IGNORE, MODE_WRITE, MODE_READ} xfer_mode_e;

   function automatic logic is_writable(input logic [7:0] addr);
      return (addr < ADDR_LIMIT) && (addr != ADDR_DEVID) && (addr != ADDR_REVID) &&
             (addr != ADDR_X) && (addr != ADDR_Y) && (addr != ADDR_Z);
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into clk and produces registered edge strobes.
// Strobes, the CS level and the MOSI bit are all aligned SYNC_STAGES+1 cycles after the pin.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic spi_clk,
   input  logic cs_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic cs_level,
   output logic mosi_bit
);

   logic [SYNC_STAGES-1:0] sclk_ff;
   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic                   sclk_prev;
   logic                   cs_prev;

   // CS resets to "low" so a transfer already in progress at reset release
   // produces no falling edge until CS has been seen high again.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_ff   <= '0;
         cs_ff     <= '0;
         mosi_ff   <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         cs_fall   <= 1'b0;
         cs_rise   <= 1'b0;
         cs_level  <= 1'b0;
         mosi_bit  <= 1'b0;
      end else begin
         sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], spi_clk};
         cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs_n};
         mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_ff[SYNC_STAGES-1];
         cs_prev   <= cs_ff[SYNC_STAGES-1];
         sclk_rise <= sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
         sclk_fall <= ~sclk_ff[SYNC_STAGES-1] & sclk_prev;
         cs_rise   <= cs_ff[SYNC_STAGES-1] & ~cs_prev;
         cs_fall   <= ~cs_ff[SYNC_STAGES-1] & cs_prev;
         cs_level  <= cs_ff[SYNC_STAGES-1];
         mosi_bit  <= mosi_ff[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 register responder for accelerometer samples: write/read bursts into a 64x8 map.
//
// state | meaning
// IDLE  | CS high (or not yet re-armed after reset), waiting for CS falling
// CMD   | shifting in the command byte
// ADDR  | shifting in the address byte that loads ptr
// DATA  | burst phase: write, read or ignore according to mode
module spi_accel_responder
   import spi_accel_responder_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID_VAL   = DEVID_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       CS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic       sample_valid,
   input  logic [7:0] sample_x,
   input  logic [7:0] sample_y,
   input  logic [7:0] sample_z,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_level, mosi_bit;

   spi_state_e state, next_state;
   xfer_mode_e mode, next_mode;

   logic [7:0] shift_in;
   logic [2:0] bit_cnt;
   logic [7:0] byte_val;
   logic       byte_done;
   logic [7:0] ptr;
   logic [7:0] miso_sr;
   logic       skip_fall;
   logic       load_ptr, do_write, do_load_miso;
   logic [7:0] rd_addr, rd_data;

   logic [7:0] regs [REG_DEPTH];
   logic [7:0] shadow_x, shadow_y, shadow_z;
   logic       pending;
   logic       cs_seen_high;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
      .clk       (clk),
      .rst       (rst),
      .spi_clk   (spi_clk),
      .cs_n      (CS),
      .mosi      (MOSI),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .cs_level  (cs_level),
      .mosi_bit  (mosi_bit)
   );

   assign byte_val  = {shift_in[6:0], mosi_bit};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
   assign rd_addr   = (state == ADDR) ? byte_val : ptr;
   assign rd_data   = (rd_addr < ADDR_LIMIT) ? regs[rd_addr[5:0]] : 8'h00;
   assign MISO      = (state == DATA) && (mode == MODE_READ) && miso_sr[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mode  <= MODE_IGNORE;
      end else begin
         state <= next_state;
         mode  <= next_mode;
      end
   end

   always_comb begin
      next_state   = state;
      next_mode    = mode;
      load_ptr     = 1'b0;
      do_write     = 1'b0;
      do_load_miso = 1'b0;
      if (cs_rise) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (cs_fall) next_state = CMD;
            CMD: if (byte_done) begin
               if (byte_val == CMD_WRITE) begin
                  next_mode  = MODE_WRITE;
                  next_state = ADDR;
               end else if (byte_val == CMD_READ) begin
                  next_mode  = MODE_READ;
                  next_state = ADDR;
               end else begin
                  next_mode  = MODE_IGNORE;
                  next_state = DATA;
               end
            end
            ADDR: if (byte_done) begin
               load_ptr     = 1'b1;
               do_load_miso = (mode == MODE_READ);
               next_state   = DATA;
            end
            DATA: if (byte_done) begin
               do_write     = (mode == MODE_WRITE);
               do_load_miso = (mode == MODE_READ);
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // A fresh load lands just after the 8th rising edge; the falling edge that
   // follows must not shift, so the MSB is still on MISO at the next rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_in  <= '0;
         bit_cnt   <= '0;
         ptr       <= '0;
         miso_sr   <= '0;
         skip_fall <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         if (state == IDLE || cs_rise) begin
            shift_in <= '0;
            bit_cnt  <= '0;
         end else if (sclk_rise) begin
            shift_in <= byte_val;
            bit_cnt  <= bit_cnt + 3'd1;
         end

         wr_strobe <= do_write;
         if (do_write) begin
            wr_addr <= ptr;
            wr_data <= byte_val;
            ptr     <= ptr + 8'd1;
         end
         if (load_ptr) ptr <= byte_val;

         if (do_load_miso) begin
            miso_sr   <= rd_data;
            ptr       <= rd_addr + 8'd1;
            skip_fall <= 1'b1;
         end else if (sclk_fall && state == DATA) begin
            if (skip_fall) skip_fall <= 1'b0;
            else           miso_sr   <= {miso_sr[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_seen_high <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if (cs_level) cs_seen_high <= 1'b1;
         busy <= ~cs_level & cs_seen_high;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
         regs[ADDR_DEVID[5:0]] <= DEVID_VAL;
         regs[ADDR_REVID[5:0]] <= REVID_VAL;
         shadow_x <= '0;
         shadow_y <= '0;
         shadow_z <= '0;
         pending  <= 1'b0;
      end else begin
         if (do_write && is_writable(ptr)) regs[ptr[5:0]] <= byte_val;

         // A live strobe always beats a pending commit.
         if (sample_valid && !busy) begin
            regs[ADDR_X[5:0]] <= sample_x;
            regs[ADDR_Y[5:0]] <= sample_y;
            regs[ADDR_Z[5:0]] <= sample_z;
            pending <= 1'b0;
         end else if (sample_valid) begin
            shadow_x <= sample_x;
            shadow_y <= sample_y;
            shadow_z <= sample_z;
            pending  <= 1'b1;
         end else if (pending && !busy) begin
            regs[ADDR_X[5:0]] <= shadow_x;
            regs[ADDR_Y[5:0]] <= shadow_y;
            regs[ADDR_Z[5:0]] <= shadow_z;
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: SPI mode-0 master model with hand-computed expectations.
module tb_spi_accel_responder;

   logic       clk;
   logic       rst;
   logic       spi_clk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       sample_valid;
   logic [7:0] sample_x, sample_y, sample_z;
   logic       wr_strobe;
   logic [7:0] wr_addr, wr_data;
   logic       busy;

   int         n_tests;
   int         n_fail;
   int         wr_cnt;
   logic [7:0] wa_log [32];
   logic [7:0] wd_log [32];
   logic [7:0] b0, b1, b2;
   int         base;

   spi_accel_responder dut (
      .clk          (clk),
      .rst          (rst),
      .spi_clk      (spi_clk),
      .CS           (cs),
      .MOSI         (mosi),
      .MISO         (miso),
      .sample_valid (sample_valid),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .sample_z     (sample_z),
      .wr_strobe    (wr_strobe),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (wr_strobe && wr_cnt < 32) begin
         wa_log[wr_cnt] = wr_addr;
         wd_log[wr_cnt] = wr_data;
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // spi_clk runs at clk/8; bits are sampled just before each rising edge.
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = tx[i];
         #40;
         rx[i] = miso;
         spi_clk = 1'b1;
         #40;
         spi_clk = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40;
      cs = 1'b1;
      #200;
   endtask

   task automatic rd3(input logic [7:0] addr, output logic [7:0] r0, output logic [7:0] r1,
                      output logic [7:0] r2);
      logic [7:0] dummy;
      cs_low();
      xfer(8'h0B, 8, dummy);
      xfer(addr, 8, dummy);
      xfer(8'h00, 8, r0);
      xfer(8'h00, 8, r1);
      xfer(8'h00, 8, r2);
      cs_high();
   endtask

   task automatic sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      @(negedge clk);
      sample_x = x;
      sample_y = y;
      sample_z = z;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      wr_cnt = 0;
      rst = 1'b1;
      spi_clk = 1'b0;
      cs = 1'b1;
      mosi = 1'b0;
      sample_valid = 1'b0;
      sample_x = 8'h00;
      sample_y = 8'h00;
      sample_z = 8'h00;

      repeat (5) @(negedge clk);
      check("rst_miso", miso, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_busy", busy, 0);

      sample(8'h31, 8'h32, 8'h33);

      // Device ID / revision read
      cs_low();
      xfer(8'h0B, 8, b0);
      check("busy_in_xfer", busy, 1);
      xfer(8'h00, 8, b0);
      xfer(8'h00, 8, b0);
      xfer(8'h00, 8, b1);
      cs_high();
      check("read_devid", b0, 8'hAD);
      check("read_revid", b1, 8'h1D);
      check("busy_after_cs", busy, 0);

      // Burst write then read back
      base = wr_cnt;
      cs_low();
      xfer(8'h0A, 8, b0);
      xfer(8'h20, 8, b0);
      xfer(8'h55, 8, b0);
      xfer(8'hAA, 8, b0);
      cs_high();
      check("burst_wr_count", wr_cnt - base, 2);
      check("burst_wr0_addr", wa_log[base], 8'h20);
      check("burst_wr0_data", wd_log[base], 8'h55);
      check("burst_wr1_addr", wa_log[base+1], 8'h21);
      check("burst_wr1_data", wd_log[base+1], 8'hAA);
      check("wr_addr_held", wr_addr, 8'h21);
      check("wr_data_held", wr_data, 8'hAA);
      rd3(8'h20, b0, b1, b2);
      check("readback_20", b0, 8'h55);
      check("readback_21", b1, 8'hAA);

      // Write to read-only sample register
      base = wr_cnt;
      cs_low();
      xfer(8'h0A, 8, b0);
      xfer(8'h08, 8, b0);
      xfer(8'h77, 8, b0);
      cs_high();
      check("prot_wr_count", wr_cnt - base, 1);
      check("prot_wr_addr", wa_log[base], 8'h08);
      check("prot_wr_data", wd_log[base], 8'h77);
      rd3(8'h08, b0, b1, b2);
      check("prot_x", b0, 8'h31);
      check("prot_y", b1, 8'h32);
      check("prot_z", b2, 8'h33);

      // Samples arriving mid-transaction are deferred; the newest one wins
      cs_low();
      xfer(8'h0B, 8, b0);
      sample(8'h11, 8'h21, 8'h31);
      sample(8'h12, 8'h22, 8'h23);
      check("defer_busy", busy, 1);
      xfer(8'h08, 8, b0);
      xfer(8'h00, 8, b0);
      cs_high();
      check("defer_old_x", b0, 8'h31);
      rd3(8'h08, b0, b1, b2);
      check("defer_new_x", b0, 8'h12);
      check("defer_new_y", b1, 8'h22);
      check("defer_new_z", b2, 8'h23);

      // CS abort mid address byte, then a clean read
      cs_low();
      xfer(8'h0B, 8, b0);
      xfer(8'h00, 4, b0);
      cs_high();
      rd3(8'h00, b0, b1, b2);
      check("abort_devid", b0, 8'hAD);
      check("abort_revid", b1, 8'h1D);

      // Unknown command: no output, no writes
      base = wr_cnt;
      cs_low();
      xfer(8'h3C, 8, b0);
      xfer(8'h20, 8, b1);
      xfer(8'h99, 8, b2);
      check("badcmd_miso_a", b1, 8'h00);
      check("badcmd_miso_b", b2, 8'h00);
      cs_high();
      check("badcmd_no_wr", wr_cnt - base, 0);
      rd3(8'h20, b0, b1, b2);
      check("badcmd_reg20", b0, 8'h55);

      // Pointer wrap
      rd3(8'hFF, b0, b1, b2);
      check("wrap_ff", b0, 8'h00);
      check("wrap_00", b1, 8'hAD);
      check("wrap_01", b2, 8'h1D);

      // Writes crossing the end of the register file
      base = wr_cnt;
      cs_low();
      xfer(8'h0A, 8, b0);
      xfer(8'h3F, 8, b0);
      xfer(8'h66, 8, b0);
      xfer(8'h77, 8, b0);
      cs_high();
      check("edge_wr_count", wr_cnt - base, 2);
      check("edge_wr1_addr", wa_log[base+1], 8'h40);
      rd3(8'h3F, b0, b1, b2);
      check("edge_3f", b0, 8'h66);
      check("edge_40", b1, 8'h00);

      // Reset in the middle of a write transfer
      cs_low();
      xfer(8'h0A, 8, b0);
      xfer(8'h30, 8, b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_wr_data", wr_data, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst_busy", busy, 0);
      base = wr_cnt;
      xfer(8'h44, 8, b0);
      xfer(8'h45, 8, b0);
      cs_high();
      check("midrst_no_wr", wr_cnt - base, 0);
      rd3(8'h30, b0, b1, b2);
      check("midrst_reg30", b0, 8'h00);
      rd3(8'h20, b0, b1, b2);
      check("midrst_reg20", b0, 8'h00);
      rd3(8'h00, b0, b1, b2);
      check("midrst_devid", b0, 8'hAD);
      check("midrst_miso_idle", miso, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
